mc_sequencer: RTL and testbench
===============================

# mc_sequencer

Multi-cycle sequencer for the RV32I datapath. Walks each instruction through FETCH, DECODE, EXEC, MEM and WB states, and drives the register-file, ALU, immediate, PC and memory-handshake controls. It sits between the shared instruction/data memory port and the datapath, so one memory serves both fetch and load/store. It supports OP, OP-IMM, LOAD, STORE and BEQ/BNE, and traps on anything else.

## Interface
- AW, 32, instruction width
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- instr_i  in  AW  current instruction-register contents
- Eq_i  in  1  datapath comparator, rs1 == rs2
- mem_ready_i  in  1  memory completes the pending request this cycle
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  request is a write
- adr_src_o  out  1  memory address: 0 = PC, 1 = ALU result
- ir_we_o  out  1  load instruction register
- pc_we_o  out  1  update PC
- PCsrc_o  out  1  next PC: 0 = PC+4, 1 = branch target
- RegWrite_o  out  1  register-file write enable
- result_src_o  out  1  writeback: 0 = ALU, 1 = memory data
- ALUctrl_o  out  3  ALU operation
- ALUsrc_o  out  1  ALU operand B: 0 = rs2, 1 = immediate
- ImmSrc_o  out  3  000 = I, 001 = B, 010 = S
- trap_o  out  1  illegal opcode seen; sticky
- perf_cycle_o  out  32  cycle counter (only with MC_PERF_EN)
- perf_instret_o  out  32  retired-instruction counter (only with MC_PERF_EN)

## Operation
- **State register:** the only sequential control state. States are FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are decoded combinationally from state and instr_i.
- **FETCH:** mem_req_o=1, mem_we_o=0, adr_src_o=0.
  - Hold in FETCH while mem_ready_i=0.
  - On mem_ready_i=1: ir_we_o=1 for that cycle, then go to DECODE.
- **DECODE:** one cycle, no writes. Next state depends on opcode:
  - 19, 51, 3, 35, 99 go to EXEC.
  - Any other opcode goes to TRAP.
  - Opcode 99 with funct3 other than 000/001 goes to TRAP.
- **EXEC:** one cycle, action depends on opcode:
  - OP (51): ALUctrl_o=funct3, ALUsrc_o=0, then go to WB.
  - OP-IMM (19): ALUctrl_o=funct3, ALUsrc_o=1, ImmSrc_o=000, then go to WB.
  - LOAD (3): ALUctrl_o=000, ALUsrc_o=1, ImmSrc_o=000, then go to MEM.
  - STORE (35): ALUctrl_o=000, ALUsrc_o=1, ImmSrc_o=010, then go to MEM.
  - BRANCH (99): ImmSrc_o=001, ALUsrc_o=0, pc_we_o=1, then go to FETCH.
    - PCsrc_o = Eq_i when funct3=000 (BEQ).
    - PCsrc_o = !Eq_i when funct3=001 (BNE).
- **MEM:** mem_req_o=1, adr_src_o=1, mem_we_o=1 for STORE only. Hold while mem_ready_i=0.
  - On ready, LOAD goes to WB.
  - On ready, STORE asserts pc_we_o=1 with PCsrc_o=0 and goes to FETCH.
- **WB:** RegWrite_o=1, pc_we_o=1, PCsrc_o=0, then go to FETCH.
  - result_src_o=1 for LOAD, 0 otherwise.
- **TRAP:** trap_o=1, every write enable and mem_req_o held at 0. Only rst_i leaves TRAP.
- **Handshake:** while mem_req_o=1 and mem_ready_i=0, the following stay stable: mem_we_o, adr_src_o and all ALU/immediate selects. mem_ready_i is ignored whenever mem_req_o=0.
- **Output defaults:** any output not driven by the current state is 0, including ALUctrl_o, ImmSrc_o and the select lines.

## Timing
- **Reset:**
  - State goes to FETCH on the first rising edge with rst_i=1.
  - While rst_i=1, all outputs are 0 and trap_o is cleared.
  - In the first cycle after rst_i drops, mem_req_o=1.
  - Reset during MEM or FETCH abandons the request; no write enable pulses.
- **Zero-wait-memory latency (mem_ready_i tied 1):**
  - OP/OP-IMM: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Each wait cycle with mem_ready_i=0 adds one cycle.
- **Single-cycle pulses:** pc_we_o, ir_we_o and RegWrite_o are each high for exactly one cycle per instruction.
- **Retire cycle:** the cycle with pc_we_o=1 is the retire cycle.
- **Eq_i:** sampled only in EXEC, combinationally into PCsrc_o.

## Configuration
- **MC_PERF_EN defined:**
  - perf_cycle_o increments every non-reset cycle.
  - perf_instret_o increments on each pc_we_o=1 cycle.
  - Both counters are cleared by rst_i and wrap modulo 2^32.
  - Neither counter increments in TRAP except perf_cycle_o.
- **MC_PERF_EN undefined:** both perf ports are absent, and there are no counter registers.

## Structure
- **Package mc_pkg:**
  - state enum, 3 bits.
  - Opcode constants OPC_OP=51, OPC_OPIMM=19, OPC_LOAD=3, OPC_STORE=35, OPC_BRANCH=99.
  - ImmSrc constants IMM_I, IMM_B, IMM_S.
  - funct3 constants F3_BEQ, F3_BNE.
- **Sub-module mc_decode:** combinational opcode/funct3 classification. Outputs per-class flags and a legal flag. Instantiated once.

## Test plan
- **Zero-wait OP:** rst_i 2 cycles, then instr_i=0x002081B3 (add x3,x1,x2), mem_ready_i=1.
  - ir_we_o at cycle 1.
  - RegWrite_o and pc_we_o with PCsrc_o=0 at cycle 4.
  - ALUsrc_o=0 in EXEC.
- **LOAD with memory stalls:** instr_i=0x0040A183 (lw), 2 stall cycles in MEM.
  - mem_req_o, adr_src_o=1 and mem_we_o=0 stay stable for 3 cycles.
  - WB then has result_src_o=1 and RegWrite_o=1.
  - Total 7 cycles.
- **BNE both ways:** instr_i=0x00209463.
  - Eq_i=0: PCsrc_o=1 and pc_we_o in EXEC.
  - Eq_i=1: PCsrc_o=0.
  - RegWrite_o never asserts.
- **STORE:** instr_i=0x0020A223 (sw).
  - MEM has mem_we_o=1 and ImmSrc_o=010.
  - pc_we_o in the mem_ready_i cycle.
  - RegWrite_o stays 0.
- **Illegal opcode:** instr_i=0x0000007F.
  - TRAP after DECODE; trap_o=1 holds for 10 cycles with no mem_req_o.
  - rst_i clears trap_o and returns to FETCH.
- **Reset mid-MEM, with MC_PERF_EN:** assert rst_i mid-MEM.
  - mem_req_o=0 next cycle, no pc_we_o.
  - Counters read 0.
  - After 3 zero-wait ADDs, perf_instret_o=3 and perf_cycle_o=12.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the RV32I multi-cycle sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'd51;
  localparam logic [6:0] OPC_OPIMM  = 7'd19;
  localparam logic [6:0] OPC_LOAD   = 7'd3;
  localparam logic [6:0] OPC_STORE  = 7'd35;
  localparam logic [6:0] OPC_BRANCH = 7'd99;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_B = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [2:0] ALU_ADD = 3'b000;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct3 classification feeding the sequencer FSM.
module mc_decode
  import mc_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic       is_op,
  output logic       is_opimm,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       legal
);

  logic branch_f3_ok;

  always_comb begin
    is_op        = (opcode == OPC_OP);
    is_opimm     = (opcode == OPC_OPIMM);
    is_load      = (opcode == OPC_LOAD);
    is_store     = (opcode == OPC_STORE);
    is_branch    = (opcode == OPC_BRANCH);
    // Only BEQ/BNE are implemented; other branch flavours trap.
    branch_f3_ok = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
    legal        = is_op || is_opimm || is_load || is_store ||
                   (is_branch && branch_f3_ok);
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I datapath.
// Optional MC_PERF_EN adds cycle and retired-instruction counters.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] instr_i,
  input  logic          Eq_i,
  input  logic          mem_ready_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic          adr_src_o,
  output logic          ir_we_o,
  output logic          pc_we_o,
  output logic          PCsrc_o,
  output logic          RegWrite_o,
  output logic          result_src_o,
  output logic [2:0]    ALUctrl_o,
  output logic          ALUsrc_o,
  output logic [2:0]    ImmSrc_o,
  output logic          trap_o
`ifdef MC_PERF_EN
  ,
  output logic [31:0]   perf_cycle_o,
  output logic [31:0]   perf_instret_o
`endif
);

  state_t     state_reg, state_next;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_op, is_opimm, is_load, is_store, is_branch, legal;
  logic       unused_instr_bits;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign unused_instr_bits = ^{instr_i[AW-1:15], instr_i[11:7]};

  mc_decode u_decode (
    .opcode    (opcode),
    .funct3    (funct3),
    .is_op     (is_op),
    .is_opimm  (is_opimm),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .legal     (legal)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    adr_src_o    = 1'b0;
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    PCsrc_o      = 1'b0;
    RegWrite_o   = 1'b0;
    result_src_o = 1'b0;
    ALUctrl_o    = ALU_ADD;
    ALUsrc_o     = 1'b0;
    ImmSrc_o     = IMM_I;
    trap_o       = 1'b0;
    // Everything is forced low while reset is held, whatever the state register holds.
    if (!rst_i) begin
      case (state_reg)
        S_FETCH: begin
          mem_req_o = 1'b1;
          if (mem_ready_i) begin
            ir_we_o    = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          state_next = legal ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          if (is_op) begin
            ALUctrl_o  = funct3;
            state_next = S_WB;
          end else if (is_opimm) begin
            ALUctrl_o  = funct3;
            ALUsrc_o   = 1'b1;
            ImmSrc_o   = IMM_I;
            state_next = S_WB;
          end else if (is_load || is_store) begin
            ALUsrc_o   = 1'b1;
            ImmSrc_o   = is_store ? IMM_S : IMM_I;
            state_next = S_MEM;
          end else if (is_branch) begin
            ImmSrc_o   = IMM_B;
            pc_we_o    = 1'b1;
            PCsrc_o    = (funct3 == F3_BNE) ? !Eq_i : Eq_i;
            state_next = S_FETCH;
          end else begin
            state_next = S_TRAP;
          end
        end
        S_MEM: begin
          // The ALU keeps producing the address, so its selects stay as in EXEC.
          mem_req_o = 1'b1;
          adr_src_o = 1'b1;
          mem_we_o  = is_store;
          ALUsrc_o  = 1'b1;
          ImmSrc_o  = is_store ? IMM_S : IMM_I;
          if (mem_ready_i) begin
            if (is_store) begin
              pc_we_o    = 1'b1;
              state_next = S_FETCH;
            end else begin
              state_next = S_WB;
            end
          end
        end
        S_WB: begin
          RegWrite_o   = 1'b1;
          pc_we_o      = 1'b1;
          result_src_o = is_load;
          state_next   = S_FETCH;
        end
        S_TRAP: begin
          trap_o = 1'b1;
        end
        default: begin
          state_next = S_FETCH;
        end
      endcase
    end
  end

`ifdef MC_PERF_EN
  logic [31:0] perf_cycle_reg, perf_instret_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_cycle_reg   <= 32'd0;
      perf_instret_reg <= 32'd0;
    end else begin
      perf_cycle_reg <= perf_cycle_reg + 32'd1;
      if (pc_we_o) begin
        perf_instret_reg <= perf_instret_reg + 32'd1;
      end
    end
  end

  assign perf_cycle_o   = rst_i ? 32'd0 : perf_cycle_reg;
  assign perf_instret_o = rst_i ? 32'd0 : perf_instret_reg;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: per-cycle expected control vectors are queued, then compared.
module tb_mc_sequencer;

  logic        clk = 1'b0;
  logic        rst, eq, rdy;
  logic [31:0] instr;
  logic        mem_req, mem_we, adr_src, ir_we, pc_we, pcsrc, reg_write, result_src;
  logic [2:0]  alu_ctrl, imm_src;
  logic        alu_src, trap;
`ifdef MC_PERF_EN
  logic [31:0] perf_cycle, perf_instret;
`endif

  always #5 clk = ~clk;

  mc_sequencer #(.AW(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .instr_i      (instr),
    .Eq_i         (eq),
    .mem_ready_i  (rdy),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .adr_src_o    (adr_src),
    .ir_we_o      (ir_we),
    .pc_we_o      (pc_we),
    .PCsrc_o      (pcsrc),
    .RegWrite_o   (reg_write),
    .result_src_o (result_src),
    .ALUctrl_o    (alu_ctrl),
    .ALUsrc_o     (alu_src),
    .ImmSrc_o     (imm_src),
    .trap_o       (trap)
`ifdef MC_PERF_EN
    ,
    .perf_cycle_o   (perf_cycle),
    .perf_instret_o (perf_instret)
`endif
  );

  // Packed view: {req,we,adr,irwe,pcwe,pcsrc,rw,rs,alu[2:0],asrc,imm[2:0],trap}
  logic [15:0] obs;
  assign obs = {mem_req, mem_we, adr_src, ir_we, pc_we, pcsrc, reg_write, result_src,
                alu_ctrl, alu_src, imm_src, trap};

  localparam logic [15:0] M_REQ  = 16'h8000;
  localparam logic [15:0] M_WE   = 16'h4000;
  localparam logic [15:0] M_ADR  = 16'h2000;
  localparam logic [15:0] M_IRW  = 16'h1000;
  localparam logic [15:0] M_PCW  = 16'h0800;
  localparam logic [15:0] M_PCS  = 16'h0400;
  localparam logic [15:0] M_RW   = 16'h0200;
  localparam logic [15:0] M_RS   = 16'h0100;
  localparam logic [15:0] M_ASRC = 16'h0010;
  localparam logic [15:0] M_TRAP = 16'h0001;
  localparam logic [15:0] X_IDLE = 16'h0000;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_XOR  = 32'h0020C1B3;
  localparam logic [31:0] I_ORI  = 32'h0010E193;
  localparam logic [31:0] I_LW   = 32'h0040A183;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BBAD = 32'h0020A463;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  function automatic logic [15:0] alu(input logic [2:0] a);
    return {8'h00, a, 5'h00};
  endfunction

  function automatic logic [15:0] imm(input logic [2:0] s);
    return {12'h000, s, 1'b0};
  endfunction

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        eq;
    logic [31:0] instr;
    logic [15:0] exp;
    logic        chk_perf;
    logic [31:0] exp_cycle;
    logic [31:0] exp_instret;
  } step_t;

  step_t sb[$];
  int    checks = 0;
  int    passed = 0;

  task automatic push(input logic r, input logic rd, input logic e,
                      input logic [31:0] ins, input logic [15:0] x);
    sb.push_back('{r, rd, e, ins, x, 1'b0, 32'd0, 32'd0});
  endtask

  task automatic push_perf(input logic [31:0] ins, input logic rd, input logic [15:0] x,
                           input logic [31:0] c, input logic [31:0] n);
    sb.push_back('{1'b0, rd, 1'b0, ins, x, 1'b1, c, n});
  endtask

  // Zero-wait register-register instruction: FETCH, DECODE, EXEC, WB.
  task automatic push_op(input logic [31:0] ins, input logic [15:0] exec_exp);
    push(0, 1, 0, ins, M_REQ | M_IRW);
    push(0, 1, 0, ins, X_IDLE);
    push(0, 1, 0, ins, exec_exp);
    push(0, 1, 0, ins, M_RW | M_PCW);
  endtask

  task automatic test_reset;
    step_t s;
    int n = 0;
    push(1, 1, 1, I_ADD, X_IDLE);
    push(1, 1, 1, I_ADD, X_IDLE);
    push(0, 0, 0, I_ADD, M_REQ);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); rst = s.rst; rdy = s.rdy; eq = s.eq; instr = s.instr; #1;
      checks++;
      if (obs !== s.exp) $display("FAIL reset cyc %0d: got %h want %h", n, obs, s.exp);
      else passed++;
      n++;
    end
  endtask

  task automatic test_op;
    step_t s;
    int n = 0;
    push_op(I_ADD, X_IDLE);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); rst = s.rst; rdy = s.rdy; eq = s.eq; instr = s.instr; #1;
      checks++;
      if (obs !== s.exp) $display("FAIL op_add cyc %0d: got %h want %h", n, obs, s.exp);
      else passed++;
      n++;
    end
  endtask

  task automatic test_load_stall;
    step_t s;
    int n = 0;
    push(0, 1, 0, I_LW, M_REQ | M_IRW);
    push(0, 1, 0, I_LW, X_IDLE);
    push(0, 1, 0, I_LW, M_ASRC);
    push(0, 0, 0, I_LW, M_REQ | M_ADR | M_ASRC);
    push(0, 0, 1, I_LW, M_REQ | M_ADR | M_ASRC);
    push(0, 1, 0, I_LW, M_REQ | M_ADR | M_ASRC);
    push(0, 1, 0, I_LW, M_RW | M_PCW | M_RS);
    push(0, 0, 0, I_LW, M_REQ);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); rst = s.rst; rdy = s.rdy; eq = s.eq; instr = s.instr; #1;
      checks++;
      if (obs !== s.exp) $display("FAIL load_stall cyc %0d: got %h want %h", n, obs, s.exp);
      else passed++;
      n++;
    end
  endtask

  task automatic test_bne;
    step_t s;
    int n = 0;
    // Eq_i is driven opposite outside EXEC to show it only matters there.
    push(0, 1, 1, I_BNE, M_REQ | M_IRW);
    push(0, 1, 1, I_BNE, X_IDLE);
    push(0, 1, 0, I_BNE, M_PCW | M_PCS | imm(3'b001));
    push(0, 1, 0, I_BNE, M_REQ | M_IRW);
    push(0, 1, 0, I_BNE, X_IDLE);
    push(0, 1, 1, I_BNE, M_PCW | imm(3'b001));
    push(0, 0, 0, I_BNE, M_REQ);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); rst = s.rst; rdy = s.rdy; eq = s.eq; instr = s.instr; #1;
      checks++;
      if (obs !== s.exp) $display("FAIL bne cyc %0d: got %h want %h", n, obs, s.exp);
      else passed++;
      n++;
    end
  endtask

  task automatic test_store;
    step_t s;
    int n = 0;
    push(0, 1, 0, I_SW, M_REQ | M_IRW);
    push(0, 1, 0, I_SW, X_IDLE);
    push(0, 1, 0, I_SW, M_ASRC | imm(3'b010));
    push(0, 0, 0, I_SW, M_REQ | M_WE | M_ADR | M_ASRC | imm(3'b010));
    push(0, 1, 0, I_SW, M_REQ | M_WE | M_ADR | M_ASRC | imm(3'b010) | M_PCW);
    push(0, 0, 0, I_SW, M_REQ);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); rst = s.rst; rdy = s.rdy; eq = s.eq; instr = s.instr; #1;
      checks++;
      if (obs !== s.exp) $display("FAIL store cyc %0d: got %h want %h", n, obs, s.exp);
      else passed++;
      n++;
    end
  endtask

  task automatic test_back_to_back;
    step_t s;
    int n = 0;
    push(0, 0, 0, I_XOR, M_REQ);
    push_op(I_XOR, alu(3'b100));
    push_op(I_ORI, alu(3'b110) | M_ASRC);
    push(0, 1, 1, I_BEQ, M_REQ | M_IRW);
    push(0, 1, 1, I_BEQ, X_IDLE);
    push(0, 1, 1, I_BEQ, M_PCW | M_PCS | imm(3'b001));
    push(0, 0, 0, I_BEQ, M_REQ);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); rst = s.rst; rdy = s.rdy; eq = s.eq; instr = s.instr; #1;
      checks++;
      if (obs !== s.exp) $display("FAIL back_to_back cyc %0d: got %h want %h", n, obs, s.exp);
      else passed++;
      n++;
    end
  endtask

  task automatic test_trap;
    step_t s;
    int n = 0;
    push(0, 1, 0, I_ILL, M_REQ | M_IRW);
    push(0, 1, 0, I_ILL, X_IDLE);
    for (int i = 0; i < 10; i++) push(0, 1, i[0], I_ILL, M_TRAP);
    push(1, 1, 0, I_ILL, X_IDLE);
    push(0, 0, 0, I_ILL, M_REQ);
    // Branch with an unsupported funct3 must trap too.
    push(0, 1, 0, I_BBAD, M_REQ | M_IRW);
    push(0, 1, 0, I_BBAD, X_IDLE);
    push(0, 1, 0, I_BBAD, M_TRAP);
    push(0, 1, 0, I_BBAD, M_TRAP);
    push(1, 1, 0, I_BBAD, X_IDLE);
    push(0, 0, 0, I_BBAD, M_REQ);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); rst = s.rst; rdy = s.rdy; eq = s.eq; instr = s.instr; #1;
      checks++;
      if (obs !== s.exp) $display("FAIL trap cyc %0d: got %h want %h", n, obs, s.exp);
      else passed++;
      n++;
    end
  endtask

  task automatic test_reset_mid_mem;
    step_t s;
    int n = 0;
    push(0, 1, 0, I_LW, M_REQ | M_IRW);
    push(0, 1, 0, I_LW, X_IDLE);
    push(0, 1, 0, I_LW, M_ASRC);
    push(0, 0, 0, I_LW, M_REQ | M_ADR | M_ASRC);
    push(1, 1, 0, I_LW, X_IDLE);
    push_perf(I_ADD, 1, M_REQ | M_IRW, 32'd0, 32'd0);
    push(0, 1, 0, I_ADD, X_IDLE);
    push(0, 1, 0, I_ADD, X_IDLE);
    push(0, 1, 0, I_ADD, M_RW | M_PCW);
    push_op(I_ADD, X_IDLE);
    push_op(I_ADD, X_IDLE);
    push_perf(I_ADD, 0, M_REQ, 32'd12, 32'd3);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); rst = s.rst; rdy = s.rdy; eq = s.eq; instr = s.instr; #1;
      checks++;
      if (obs !== s.exp) $display("FAIL reset_mid_mem cyc %0d: got %h want %h", n, obs, s.exp);
      else passed++;
`ifdef MC_PERF_EN
      if (s.chk_perf) begin
        checks++;
        if (perf_cycle !== s.exp_cycle)
          $display("FAIL perf_cycle cyc %0d: got %0d want %0d", n, perf_cycle, s.exp_cycle);
        else passed++;
        checks++;
        if (perf_instret !== s.exp_instret)
          $display("FAIL perf_instret cyc %0d: got %0d want %0d", n, perf_instret, s.exp_instret);
        else passed++;
      end
`endif
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    rdy   = 1'b0;
    eq    = 1'b0;
    instr = 32'd0;
    test_reset;
    test_op;
    test_load_stall;
    test_bne;
    test_store;
    test_back_to_back;
    test_trap;
    test_reset_mid_mem;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
